// File: rtl/vga_fb_scanout_if.sv
// Frame-buffer read port between the scan-out engine and the external BRAM.
// The scan-out engine drives a registered address and read enable, and the
// BRAM returns pixel data a fixed number of cycles later.
interface vga_fb_scanout_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned PIX_W  = 12
);
  logic [ADDR_W-1:0] addr;
  logic              rd_en;
  logic [PIX_W-1:0]  data_in;

  modport master (output addr, output rd_en, input data_in);
  modport slave  (input addr, input rd_en, output data_in);
endinterface

// File: rtl/vga_fb_scanout.sv
// VGA scan-out engine: raster counters, frame-buffer address generation
// (native / 2x / mirrored), BRAM latency compensation and pin drive.
module vga_fb_scanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned IMG_W    = 320,
  parameter int unsigned IMG_H    = 240,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned PIX_W    = 12,
  parameter int unsigned RD_LAT   = 1,
  parameter logic [PIX_W-1:0] BORDER = 12'h000
) (
  input  logic                    clk_25mHz,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic                    all_ready,
  vga_fb_scanout_if.master        fb,
  output logic                    vga_hs,
  output logic                    vga_vs,
  output logic [3:0]              vga_r,
  output logic [3:0]              vga_g,
  output logic [3:0]              vga_b,
  output logic                    frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] IMG_W_H  = HW'(IMG_W);
  localparam logic [HW-1:0] IMG_W_M1 = HW'(IMG_W - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] IMG_H_V  = VW'(IMG_H);
  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);

  // Per-pixel control bits that travel alongside the BRAM read.
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic img;
    logic rdy;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{hs: 1'b1, vs: 1'b1, default: 1'b0};

  logic [HW-1:0]     h;
  logic [VW-1:0]     v;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] line_base;
  logic              fs_now;
  logic [1:0]        mode_cur;
  logic              scale;
  logic              mirror;
  logic              active;
  logic              in_img;
  logic              hs_n;
  logic              vs_n;
  logic [HW-1:0]     sx;
  logic [HW-1:0]     sx_m;
  logic [VW-1:0]     sy;
  ctl_t              ctl_a;
  ctl_t              ctl_d [RD_LAT];
  ctl_t              ctl_o;
  logic [PIX_W-1:0]  pix;

  // Raster counters: h wraps at H_TOTAL, v advances on each h wrap.
  always_ff @(posedge clk_25mHz or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  // Counter-stage decode: sync, active window and source coordinates.
  // The first pixel of a frame already uses the incoming mode so that the
  // whole frame is rendered in one mode.
  always_comb begin
    fs_now   = (h == '0) && (v == '0);
    mode_cur = fs_now ? mode : mode_q;
    scale    = mode_cur[0];
    mirror   = mode_cur[1];
    active   = (h < H_ACT) && (v < V_ACT);
    sx       = scale ? (h >> 1) : h;
    sy       = scale ? (v >> 1) : v;
    in_img   = active && (sx < IMG_W_H) && (sy < IMG_H_V);
    sx_m     = mirror ? (IMG_W_M1 - sx) : sx;
    hs_n     = !((h >= HS_BEG) && (h < HS_END));
    vs_n     = !((v >= VS_BEG) && (v < VS_END));
  end

  // Mode is only taken at the start of a frame to avoid tearing.
  always_ff @(posedge clk_25mHz or posedge rst) begin
    if (rst) begin
      mode_q <= '0;
    end else if (fs_now) begin
      mode_q <= mode;
    end
  end

  // Running line base address; replaces a row*IMG_W multiply.
  always_ff @(posedge clk_25mHz or posedge rst) begin
    if (rst) begin
      line_base <= '0;
    end else if (h == H_LAST) begin
      if (v == V_LAST) begin
        line_base <= '0;
      end else if ((sy < IMG_H_V) && (!scale || v[0])) begin
        line_base <= line_base + IMG_W_A;
      end
    end
  end

  // Address stage: registered BRAM request plus the control bits for it.
  always_ff @(posedge clk_25mHz or posedge rst) begin
    if (rst) begin
      fb.addr     <= '0;
      fb.rd_en    <= 1'b0;
      frame_start <= 1'b0;
      ctl_a       <= CTL_IDLE;
    end else begin
      frame_start <= fs_now;
      fb.rd_en    <= in_img && all_ready;
      fb.addr     <= (in_img && all_ready) ? line_base + ADDR_W'(sx_m) : '0;
      ctl_a       <= '{hs: hs_n, vs: vs_n, act: active, img: in_img, rdy: all_ready};
    end
  end

  // Delay line matching the BRAM read latency.
  always_ff @(posedge clk_25mHz or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        ctl_d[i] <= CTL_IDLE;
      end
    end else begin
      ctl_d[0] <= ctl_a;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        ctl_d[i] <= ctl_d[i-1];
      end
    end
  end

  assign ctl_o = ctl_d[RD_LAT-1];

  // Output register: sync and colour leave together, aligned with BRAM data.
  always_ff @(posedge clk_25mHz or posedge rst) begin
    if (rst) begin
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      pix    <= '0;
    end else begin
      vga_hs <= ctl_o.hs;
      vga_vs <= ctl_o.vs;
      if (!ctl_o.act || !ctl_o.rdy) begin
        pix <= '0;
      end else if (ctl_o.img) begin
        pix <= fb.data_in;
      end else begin
        pix <= BORDER;
      end
    end
  end

  assign vga_r = pix[11:8];
  assign vga_g = pix[7:4];
  assign vga_b = pix[3:0];

endmodule
